mlp_eval_sequencer: RTL and testbench

Sequences a parametrised MLP inference datapath through a stored test set. For each case it fetches the golden label from an external memory, launches one inference, and waits for completion or a timeout. It then scores the prediction. It keeps total-correct, per-class-correct, timeout and run-progress counts, and reports each misprediction. The block sits between the test-vector/label memories and the MLP datapath, which owns its own layer sequencing. It is a handshake-driven evaluation controller.

---
 rtl/mlp_eval_sequencer_if.sv | 31 +++
 rtl/mlp_eval_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mlp_eval_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_eval_sequencer_if.sv
// Handshake bundle between the evaluation sequencer, the test-vector/label memories
// and the MLP datapath. The sequencer is the master.
interface mlp_eval_sequencer_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LABEL_W = 4
);
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [LABEL_W-1:0] gold_label;
  logic               mlp_start;
  logic               mlp_done;
  logic [LABEL_W-1:0] mlp_label;

  modport master (
    output mem_addr,
    output mem_rd,
    output mlp_start,
    input  gold_label,
    input  mlp_done,
    input  mlp_label
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mlp_start,
    output gold_label,
    output mlp_done,
    output mlp_label
  );
endinterface

// File: rtl/mlp_eval_sequencer.sv
// Walks an MLP datapath through a stored test set: fetch gold label, launch, wait for
// completion or timeout, then score and keep accuracy / per-class / timeout counts.
module mlp_eval_sequencer #(
  parameter int unsigned NUM_CASES   = 750,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned LABEL_W     = 4,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [ADDR_W-1:0]          i_run_len,
  mlp_eval_sequencer_if.master       io_bus,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_W-1:0]          o_correct,
  output logic [ADDR_W-1:0]          o_timeouts,
  output logic [ADDR_W-1:0]          o_cases_run,
  input  logic [LABEL_W-1:0]         i_class_sel,
  output logic [ADDR_W-1:0]          o_class_hits,
  output logic                       o_miss_valid,
  output logic [ADDR_W-1:0]          o_miss_addr,
  output logic [LABEL_W-1:0]         o_miss_label
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLaunch,
    StWait,
    StScore
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_rd;
  logic                r_mlp_start;
  logic [ADDR_W-1:0]   r_len;
  logic [LABEL_W-1:0]  r_gold;
  logic [LABEL_W-1:0]  r_pred;
  logic                r_timed_out;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_done;
  logic [ADDR_W-1:0]   r_correct;
  logic [ADDR_W-1:0]   r_timeouts;
  logic [ADDR_W-1:0]   r_cases_run;
  logic [ADDR_W-1:0]   r_class_hits [NUM_CLASSES];
  logic                r_miss_valid;
  logic [ADDR_W-1:0]   r_miss_addr;
  logic [LABEL_W-1:0]  r_miss_label;

  logic [ADDR_W-1:0]   w_len;
  logic                w_hit;
  logic                w_last;

  // A run length of zero or beyond the stored set means "the whole set".
  assign w_len  = ((i_run_len == '0) || (32'(i_run_len) > NUM_CASES)) ?
                  ADDR_W'(NUM_CASES) : i_run_len;

  // Gold labels outside the class range can never be a hit, even on an exact match.
  assign w_hit  = !r_timed_out && (r_pred == r_gold) && (32'(r_gold) < NUM_CLASSES);
  assign w_last = ((r_cases_run + ADDR_W'(1)) == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_mlp_start  <= 1'b0;
      r_len        <= '0;
      r_gold       <= '0;
      r_pred       <= '0;
      r_timed_out  <= 1'b0;
      r_to_cnt     <= '0;
      r_done       <= 1'b0;
      r_correct    <= '0;
      r_timeouts   <= '0;
      r_cases_run  <= '0;
      r_miss_valid <= 1'b0;
      r_miss_addr  <= '0;
      r_miss_label <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_class_hits[c] <= '0;
      end
    end else begin
      r_mem_rd     <= 1'b0;
      r_mlp_start  <= 1'b0;
      r_miss_valid <= 1'b0;
      if (i_abort && (r_state != StIdle)) begin
        // Abandon without scoring: counters freeze, done stays low.
        r_state <= StIdle;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_correct   <= '0;
              r_timeouts  <= '0;
              r_cases_run <= '0;
              r_mem_addr  <= '0;
              r_done      <= 1'b0;
              r_len       <= w_len;
              for (int c = 0; c < NUM_CLASSES; c++) begin
                r_class_hits[c] <= '0;
              end
              r_mem_rd    <= 1'b1;
              r_state     <= StFetch;
            end
          end
          StFetch: begin
            r_mlp_start <= 1'b1;
            r_state     <= StLaunch;
          end
          StLaunch: begin
            r_gold      <= io_bus.gold_label;
            r_to_cnt    <= '0;
            r_timed_out <= 1'b0;
            r_state     <= StWait;
          end
          StWait: begin
            // Completion on the last allowed cycle still beats the timeout.
            if (io_bus.mlp_done) begin
              r_pred  <= io_bus.mlp_label;
              r_state <= StScore;
            end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
              r_pred      <= '0;
              r_timed_out <= 1'b1;
              r_state     <= StScore;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          StScore: begin
            r_cases_run <= r_cases_run + ADDR_W'(1);
            if (w_hit) begin
              r_correct <= r_correct + ADDR_W'(1);
              for (int c = 0; c < NUM_CLASSES; c++) begin
                if (r_gold == LABEL_W'(c)) begin
                  r_class_hits[c] <= r_class_hits[c] + ADDR_W'(1);
                end
              end
            end else begin
              r_miss_valid <= 1'b1;
              r_miss_addr  <= r_mem_addr;
              r_miss_label <= r_pred;
            end
            if (r_timed_out) begin
              r_timeouts <= r_timeouts + ADDR_W'(1);
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
              r_mem_rd   <= 1'b1;
              r_state    <= StFetch;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    o_class_hits = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (i_class_sel == LABEL_W'(c)) begin
        o_class_hits = r_class_hits[c];
      end
    end
  end

  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_rd    = r_mem_rd;
  assign io_bus.mlp_start = r_mlp_start;

  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;
  assign o_correct    = r_correct;
  assign o_timeouts   = r_timeouts;
  assign o_cases_run  = r_cases_run;
  assign o_miss_valid = r_miss_valid;
  assign o_miss_addr  = r_miss_addr;
  assign o_miss_label = r_miss_label;

endmodule

// File: tb/tb_mlp_eval_sequencer.sv
// Self-checking bench for mlp_eval_sequencer: directed vector table, hand-written
// abort/reset sequences and randomized runs against a per-case arithmetic model.
module tb_mlp_eval_sequencer;
  localparam int NC      = 10;
  localparam int TMO     = 255;
  localparam int NCASES  = 750;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_abort;
  logic [9:0] i_run_len;
  logic [3:0] i_class_sel;
  logic       o_busy, o_done, o_miss_valid;
  logic [9:0] o_correct, o_timeouts, o_cases_run, o_class_hits, o_miss_addr;
  logic [3:0] o_miss_label;

  always #5 clk = ~clk;

  mlp_eval_sequencer_if #(.ADDR_W(10), .LABEL_W(4)) bus ();

  mlp_eval_sequencer #(
    .NUM_CASES(NCASES), .ADDR_W(10), .LABEL_W(4), .NUM_CLASSES(NC),
    .TIMEOUT(TMO), .TO_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_run_len(i_run_len), .io_bus(bus), .o_busy(o_busy), .o_done(o_done),
    .o_correct(o_correct), .o_timeouts(o_timeouts), .o_cases_run(o_cases_run),
    .i_class_sel(i_class_sel), .o_class_hits(o_class_hits),
    .o_miss_valid(o_miss_valid), .o_miss_addr(o_miss_addr), .o_miss_label(o_miss_label)
  );

  // Memory and datapath stand-ins
  int gold_mem  [1024];
  int pred_mem  [1024];
  int delay_mem [1024];  // cycles from mlp_start to mlp_done; 0 = never answers
  bit spur_en = 1'b0;    // also pulse mlp_done during LAUNCH
  int rem = 0;
  logic [3:0] pend;

  always @(posedge clk) begin
    bus.gold_label <= bus.mem_rd ? 4'(gold_mem[bus.mem_addr]) : 4'($urandom);
  end

  always @(posedge clk) begin
    bus.mlp_done  <= 1'b0;
    bus.mlp_label <= 4'($urandom);
    if (!rst_n) begin
      rem = 0;
    end else begin
      if (spur_en && bus.mem_rd) begin
        bus.mlp_done  <= 1'b1;
        bus.mlp_label <= 4'(pred_mem[bus.mem_addr]) ^ 4'h5;
      end
      if (bus.mlp_start) begin
        rem  = delay_mem[bus.mem_addr];
        pend = 4'(pred_mem[bus.mem_addr]);
      end
      if (rem == 1) begin
        bus.mlp_done  <= 1'b1;
        bus.mlp_label <= pend;
      end
      if (rem > 0) rem = rem - 1;
    end
  end

  typedef struct packed {
    logic [9:0] addr;
    logic [3:0] label;
  } miss_t;

  miss_t obs_q[$];
  miss_t exp_q[$];

  always @(negedge clk) begin
    if (o_miss_valid) obs_q.push_back({o_miss_addr, o_miss_label});
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: score each case straight from the rules.
  int m_correct, m_to, m_cycles;
  int m_hits [16];

  function automatic void model(input int len);
    m_correct = 0;
    m_to      = 0;
    m_cycles  = 0;
    for (int c = 0; c < 16; c++) m_hits[c] = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      int g, p, d;
      bit to;
      g  = gold_mem[i];
      p  = pred_mem[i];
      d  = delay_mem[i];
      to = (d < 1) || (d > TMO);
      m_cycles += 3 + (to ? TMO : d);
      if (!to && p == g && g < NC) begin
        m_correct++;
        m_hits[g]++;
      end else begin
        exp_q.push_back({10'(i), to ? 4'd0 : 4'(p)});
      end
      if (to) m_to++;
    end
  endfunction

  task automatic do_run(input string tag, input int rl, input int len,
                        input int ec, input int et, input int ecyc);
    int c;
    model(len);
    obs_q.delete();
    @(negedge clk);
    i_run_len = 10'(rl);
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, " mem_rd after start"}, int'(bus.mem_rd), 1);
    check({tag, " first addr"}, int'(bus.mem_addr), 0);
    check({tag, " busy"}, int'(o_busy), 1);
    check({tag, " done cleared"}, int'(o_done), 0);
    c = 0;
    while (c < ecyc + 64) begin
      @(negedge clk);
      c++;
      if (o_done) break;
    end
    check({tag, " cycles to done"}, c, ecyc);
    #1;
    check({tag, " idle at done"}, int'(o_busy), 0);
    check({tag, " correct"}, int'(o_correct), ec);
    check({tag, " timeouts"}, int'(o_timeouts), et);
    check({tag, " cases_run"}, int'(o_cases_run), len);
    check({tag, " final addr"}, int'(bus.mem_addr), len - 1);
    check({tag, " miss count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s miss%0d addr", tag, i), int'(obs_q[i].addr), int'(exp_q[i].addr));
      check($sformatf("%s miss%0d label", tag, i), int'(obs_q[i].label),
            int'(exp_q[i].label));
    end
    for (int k = 0; k < 16; k++) begin
      i_class_sel = 4'(k);
      #1;
      check($sformatf("%s class_hits[%0d]", tag, k), int'(o_class_hits), m_hits[k]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy"}, int'(o_busy), 0);
    check({tag, " done"}, int'(o_done), 0);
    check({tag, " mem_rd"}, int'(bus.mem_rd), 0);
    check({tag, " mlp_start"}, int'(bus.mlp_start), 0);
    check({tag, " miss_valid"}, int'(o_miss_valid), 0);
    check({tag, " correct"}, int'(o_correct), 0);
    check({tag, " timeouts"}, int'(o_timeouts), 0);
    check({tag, " cases_run"}, int'(o_cases_run), 0);
    check({tag, " mem_addr"}, int'(bus.mem_addr), 0);
    check({tag, " class_hits"}, int'(o_class_hits), 0);
  endtask

  typedef struct {
    int rl;
    int len;
    int gold [4];
    int pred [4];
    int dly  [4];
    bit spur;
    int ec;
    int et;
    int ecyc;
  } vec_t;

  vec_t tab [6];

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_run_len = '0; i_class_sel = 4'd1;
    for (int i = 0; i < 1024; i++) begin
      gold_mem[i] = 0; pred_mem[i] = 0; delay_mem[i] = 1;
    end
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    tab[0] = '{rl:4, len:4, gold:'{3,7,1,9}, pred:'{3,2,1,9}, dly:'{2,2,2,2},
               spur:1'b0, ec:3, et:0, ecyc:20};
    tab[1] = '{rl:2, len:2, gold:'{4,5,0,0}, pred:'{4,5,0,0}, dly:'{0,1,1,1},
               spur:1'b0, ec:1, et:1, ecyc:262};
    tab[2] = '{rl:1, len:1, gold:'{12,0,0,0}, pred:'{12,0,0,0}, dly:'{3,1,1,1},
               spur:1'b0, ec:0, et:0, ecyc:6};
    tab[3] = '{rl:3, len:3, gold:'{0,15,9,0}, pred:'{0,15,8,0}, dly:'{1,255,256,1},
               spur:1'b0, ec:1, et:1, ecyc:520};
    tab[4] = '{rl:3, len:3, gold:'{2,2,6,0}, pred:'{2,2,6,0}, dly:'{1,4,2,1},
               spur:1'b1, ec:3, et:0, ecyc:16};
    tab[5] = '{rl:2, len:2, gold:'{9,0,0,0}, pred:'{10,0,0,0}, dly:'{2,1,1,1},
               spur:1'b0, ec:1, et:0, ecyc:9};

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        gold_mem[i] = tab[v].gold[i]; pred_mem[i] = tab[v].pred[i]; delay_mem[i] = tab[v].dly[i];
      end
      spur_en = tab[v].spur;
      do_run($sformatf("vec%0d", v), tab[v].rl, tab[v].len, tab[v].ec, tab[v].et, tab[v].ecyc);
      spur_en = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d done holds", v), int'(o_done), 1);
    end

    // Abort during case 2 of 5, with a stray start in between.
    for (int i = 0; i < 5; i++) begin
      gold_mem[i] = i; pred_mem[i] = i; delay_mem[i] = 2;
    end
    obs_q.delete();
    @(negedge clk);
    i_run_len = 10'd5; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    i_run_len = 10'd1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort pre busy", int'(o_busy), 1);
    check("abort pre cases_run", int'(o_cases_run), 2);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort busy", int'(o_busy), 0);
    check("abort done", int'(o_done), 0);
    check("abort cases_run", int'(o_cases_run), 2);
    check("abort correct", int'(o_correct), 2);
    check("abort mem_addr", int'(bus.mem_addr), 2);
    repeat (5) @(negedge clk);
    check("abort stays idle", int'(o_busy), 0);
    check("abort no misses", obs_q.size(), 0);

    // Reset in the middle of case 5's WAIT.
    for (int i = 0; i < 8; i++) begin
      gold_mem[i] = i % NC; pred_mem[i] = i % NC; delay_mem[i] = 2;
    end
    @(negedge clk);
    i_run_len = 10'd8; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (27) @(negedge clk);
    check("midrst pre cases_run", int'(o_cases_run), 5);
    rst_n = 1'b0;
    i_class_sel = 4'd1;
    #1;
    check_reset_state("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_run("after_rst", 3, 3, 3, 0, 15);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int len, sel;
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        gold_mem[i] = int'($urandom_range(0, 15));
        pred_mem[i] = ($urandom_range(0, 3) != 0) ? gold_mem[i] : int'($urandom_range(0, 15));
        sel = int'($urandom_range(0, 19));
        delay_mem[i] = (sel == 0) ? 0 : (sel == 1) ? TMO : int'($urandom_range(1, 5));
      end
      model(len);
      do_run($sformatf("rnd%0d", r), len, len, m_correct, m_to, m_cycles);
    end

    // Whole-set runs: run_len 0 and run_len past the stored set.
    for (int i = 0; i < NCASES; i++) begin
      gold_mem[i] = int'($urandom_range(0, 11));
      pred_mem[i] = ($urandom_range(0, 2) != 0) ? gold_mem[i] : int'($urandom_range(0, 11));
      delay_mem[i] = int'($urandom_range(1, 3));
    end
    model(NCASES);
    do_run("len0", 0, NCASES, m_correct, m_to, m_cycles);
    do_run("len800", 800, NCASES, m_correct, m_to, m_cycles);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
